add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 100 ++++++++++
 tb/tb_add_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Four-requester round-robin arbiter sharing one WIDTH-bit adder, with a
// single registered result slot. Define ADD_ARBITER_OVF_EN to add resp_ovf.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no result held; slot is free (resp_valid=0)
// FULL  | result held until resp_ready (resp_valid=1)
module add_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  input  logic [3:0]         req_cin,
  output logic [3:0]         req_ready,
  output logic               resp_valid,
  output logic [1:0]         resp_id,
  output logic [WIDTH-1:0]   resp_sum,
  output logic               resp_cout,
`ifdef ADD_ARBITER_OVF_EN
  output logic               resp_ovf,
`endif
  input  logic               resp_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [1:0]       rr_ptr;
  logic             free;
  logic             found;
  logic             grant;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;
  logic [WIDTH:0]   add_res;

  assign free = (resp_valid == ST_EMPTY) || resp_ready;

  // First requesting index at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Reset gating keeps req_ready low while the slot is forced empty.
  assign grant     = found && free && !reset;
  assign req_ready = grant ? (4'b0001 << grant_idx) : 4'b0000;

  assign sel_a   = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b   = req_b[grant_idx*WIDTH +: WIDTH];
  assign sel_cin = req_cin[grant_idx];
  assign add_res = {1'b0, sel_a} + {1'b0, sel_b} + {{WIDTH{1'b0}}, sel_cin};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= ST_EMPTY;
      resp_id    <= 2'd0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      rr_ptr     <= 2'd0;
    end else if (grant) begin
      resp_valid <= ST_FULL;
      resp_id    <= grant_idx;
      resp_sum   <= add_res[WIDTH-1:0];
      resp_cout  <= add_res[WIDTH];
      rr_ptr     <= grant_idx + 2'd1;
    end else if (resp_valid == ST_FULL && resp_ready) begin
      resp_valid <= ST_EMPTY;
    end
  end

`ifdef ADD_ARBITER_OVF_EN
  logic ovf_next;

  assign ovf_next = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) &&
                    (add_res[WIDTH-1] != sel_a[WIDTH-1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_ovf <= 1'b0;
    end else if (grant) begin
      resp_ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Directed-vector bench for add_arbiter: table of single ops plus sequences
// for rotation, back-pressure, reset-while-full and random adds.
module tb_add_arbiter;
  localparam int W = 64;

  logic           clock = 1'b0;
  logic           reset;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_cin;
  logic [3:0]     req_ready;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_sum;
  logic           resp_cout;
  logic           resp_ready;
`ifdef ADD_ARBITER_OVF_EN
  logic           resp_ovf;
`endif

  int errors = 0;
  int checks = 0;

  add_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout),
`ifdef ADD_ARBITER_OVF_EN
    .resp_ovf(resp_ovf),
`endif
    .resp_ready(resp_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]   valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   exp_ready;
    logic         exp_valid;
    logic [1:0]   exp_id;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Junk in every slot, then the real operands in slot g (g<0: none).
  task automatic load_ops(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      req_b[i*W +: W] = 64'h1111_2222_3333_4440 | 64'(i);
    end
    req_cin = 4'b1111;
    if (g >= 0) begin
      req_a[g*W +: W] = a;
      req_b[g*W +: W] = b;
      req_cin[g]      = cin;
    end
  endtask

  task automatic chk_resp(input string name, input logic v, input logic [1:0] id,
                          input logic [W-1:0] sum, input logic cout);
    chk({name, "_valid"}, {{W{1'b0}}, resp_valid}, {{W{1'b0}}, v});
    chk({name, "_id"},    {{(W-1){1'b0}}, resp_id}, {{(W-1){1'b0}}, id});
    chk({name, "_sum"},   {1'b0, resp_sum}, {1'b0, sum});
    chk({name, "_cout"},  {{W{1'b0}}, resp_cout}, {{W{1'b0}}, cout});
  endtask

  initial begin
    int g;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W:0] rexp;

    //          valid    a                       b                       cin ready    v  id  sum                     cout
    vecs[0] = '{4'b0001, 64'd0,                  64'd0,                  1, 4'b0001, 1, 0, 64'd1,                  0};
    vecs[1] = '{4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1, 4'b0001, 1, 0, 64'd0,                  1};
    vecs[2] = '{4'b1001, 64'd5,                  64'd7,                  0, 4'b1000, 1, 3, 64'd12,                 0};
    vecs[3] = '{4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'b0001, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[4] = '{4'b0110, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 4'b0010, 1, 1, 64'd0,                  1};
    vecs[5] = '{4'b0110, 64'd123,                64'd456,                1, 4'b0100, 1, 2, 64'd580,                0};
    vecs[6] = '{4'b0000, 64'd0,                  64'd0,                  0, 4'b0000, 0, 2, 64'd580,                0};
    vecs[7] = '{4'b0011, 64'd1,                  64'd2,                  0, 4'b0001, 1, 0, 64'd3,                  0};

    // Reset state, with all requesters asking.
    reset = 1'b1;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    load_ops(-1, '0, '0, 1'b0);
    #1;
    chk("rst_ready", {61'd0, req_ready}, 65'd0);
    chk_resp("rst", 1'b0, 2'd0, '0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      g = -1;
      for (int j = 0; j < 4; j++) if (vecs[i].exp_ready[j]) g = j;
      req_valid = vecs[i].valid;
      load_ops(g, vecs[i].a, vecs[i].b, vecs[i].cin);
      #1;
      chk($sformatf("vec%0d_ready", i), {61'd0, req_ready}, {61'd0, vecs[i].exp_ready});
      @(negedge clock);
      chk_resp($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id,
               vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Rotation: reset mid-low-phase, then all four request continuously.
    reset = 1'b1;
    #2 reset = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = 64'(i*10);
      req_b[i*W +: W] = 64'd1;
    end
    req_cin = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rot%0d_ready", k), {61'd0, req_ready}, {61'd0, 4'b0001 << (k % 4)});
      @(negedge clock);
      chk_resp($sformatf("rot%0d", k), 1'b1, 2'(k % 4), 64'((k % 4) * 10 + 1), 1'b0);
    end

    // Back-pressure: held for 5 cycles, then retire+accept on one edge.
    resp_ready = 1'b0;
    req_valid = 4'b0100;
    load_ops(2, 64'd100, 64'd200, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold%0d_ready", k), {61'd0, req_ready}, 65'd0);
      @(negedge clock);
      chk_resp($sformatf("hold%0d", k), 1'b1, 2'd0, 64'd1, 1'b0);
    end
    resp_ready = 1'b1;
    #1;
    chk("swap_ready", {61'd0, req_ready}, {61'd0, 4'b0100});
    @(negedge clock);
    chk_resp("swap", 1'b1, 2'd2, 64'd301, 1'b0);

    // Reset while FULL discards the result immediately.
    resp_ready = 1'b0;
    req_valid = 4'b1010;
    load_ops(1, 64'd40, 64'd2, 1'b0);
    #1;
    chk("prerst_ready", {61'd0, req_ready}, 65'd0);
    #1 reset = 1'b1;
    #1;
    chk_resp("midrst", 1'b0, 2'd0, '0, 1'b0);
    chk("midrst_ready", {61'd0, req_ready}, 65'd0);
    @(negedge clock);
    reset = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("postrst_ready", {61'd0, req_ready}, {61'd0, 4'b0010});
    @(negedge clock);
    chk_resp("postrst", 1'b1, 2'd1, 64'd42, 1'b0);

`ifdef ADD_ARBITER_OVF_EN
    req_valid = 4'b0001;
    load_ops(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    @(negedge clock);
    chk_resp("ovf", 1'b1, 2'd0, 64'h8000_0000_0000_0000, 1'b0);
    chk("ovf_flag", {64'd0, resp_ovf}, 65'd1);
`endif

    // Random single-requester ops against a plain 65-bit sum.
    for (int n = 0; n < 300; n++) begin
      g  = int'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 8 == 0) rb = ~ra;
      rc = 1'($urandom);
      req_valid = 4'b0001 << g;
      load_ops(g, ra, rb, rc);
      rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      #1;
      chk("rand_ready", {61'd0, req_ready}, {61'd0, 4'b0001 << g});
      @(negedge clock);
      chk_resp("rand", 1'b1, 2'(g), rexp[W-1:0], rexp[W]);
`ifdef ADD_ARBITER_OVF_EN
      chk("rand_ovf", {64'd0, resp_ovf},
          {64'd0, (ra[W-1] == rb[W-1]) && (rexp[W-1] != ra[W-1])});
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
